// File: rtl/ecc_seq_alu.sv
// Limb-serial ECC ALU: WORD_SIZE-bit operands processed LIMB bits per cycle, carry and float flags held locally.
// Optional SEQ_ALU_FLUSH_EN adds i_flush to abandon an in-flight op without touching the flags.
module ecc_seq_alu #(
  parameter int WORD_SIZE = 256,
  parameter int LIMB      = 32,
  parameter int INSN      = 19
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [INSN:0]        i_insn,
  input  logic [WORD_SIZE-1:0] i_r1data,
  input  logic [WORD_SIZE-1:0] i_r2data,
`ifdef SEQ_ALU_FLUSH_EN
  input  logic                 i_flush,
`endif
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WORD_SIZE-1:0] o_result,
  output logic                 o_carry,
  output logic [8:0]           o_float
);

  localparam int NLIMB = WORD_SIZE / LIMB;
  localparam int IDXW  = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00101,
    OP_SUB  = 5'b00110,
    OP_AND  = 5'b01001,
    OP_TCS  = 5'b10100,
    OP_ADDC = 5'b10110,
    OP_GCAR = 5'b10111,
    OP_DECF = 5'b11000,
    OP_LDF  = 5'b11001
  } op_t;

  state_t                state;
  logic [WORD_SIZE-1:0]  a_q, b_q, result_q;
  logic                  chain_c, carry_q;
  logic [8:0]            float_q;
  logic [IDXW-1:0]       idx;

  logic                  flush;
  logic [4:0]            op_in;
  logic [WORD_SIZE-1:0]  a_init, b_init, sc_result, result_shift;
  logic                  c_init, is_limb;
  logic [8:0]            sc_float;
  logic [LIMB:0]         limb_sum;
  logic                  last_limb;
  logic                  unused_insn;

`ifdef SEQ_ALU_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  assign op_in       = i_insn[INSN:INSN-4];
  assign unused_insn = ^i_insn[INSN-5:0];

  // Operand conditioning at accept time: every limb op becomes a + b + c0 over the word.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    a_init    = i_r1data;
    b_init    = '0;
    c_init    = 1'b0;
    is_limb   = 1'b0;
    sc_float  = float_q;
    sc_result = WORD_SIZE'(16'hDEED);
    case (op_in)
      OP_ADD:  begin b_init = i_r2data;  is_limb = 1'b1; end
      OP_SUB:  begin b_init = ~i_r2data; c_init = 1'b1; is_limb = 1'b1; end
      OP_ADDC: begin c_init = carry_q;   is_limb = 1'b1; end
      OP_TCS:  begin a_init = '0; b_init = ~i_r1data; c_init = 1'b1; is_limb = 1'b1; end
      OP_AND:  sc_result = i_r1data & i_r2data;
      OP_GCAR: sc_result = WORD_SIZE'(carry_q);
      OP_DECF: begin sc_float = float_q - 9'd1; sc_result = WORD_SIZE'(sc_float); end
      OP_LDF:  begin sc_float = i_r1data[8:0];  sc_result = WORD_SIZE'(sc_float); end
      default: ;
    endcase
  end

  assign limb_sum     = {1'b0, a_q[LIMB-1:0]} + {1'b0, b_q[LIMB-1:0]} + {{LIMB{1'b0}}, chain_c};
  // Result fills from the top so the least-significant limb lands at bit 0 after NLIMB steps.
  assign result_shift = (result_q >> LIMB) | (WORD_SIZE'(limb_sum[LIMB-1:0]) << (WORD_SIZE - LIMB));
  assign last_limb    = (idx == IDXW'(NLIMB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand/result registers are reset too; they are flops, not a memory array.
      state    <= S_IDLE;
      o_ready  <= 1'b1;
      o_valid  <= 1'b0;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      chain_c  <= 1'b0;
      carry_q  <= 1'b0;
      float_q  <= '0;
      idx      <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            a_q     <= a_init;
            b_q     <= b_init;
            chain_c <= c_init;
            idx     <= '0;
            o_ready <= 1'b0;
            if (is_limb) begin
              state <= S_RUN;
            end else begin
              state    <= S_DONE;
              o_valid  <= 1'b1;
              result_q <= sc_result;
              float_q  <= sc_float;
            end
          end
        end
        S_RUN: begin
          if (flush) begin
            state   <= S_IDLE;
            o_ready <= 1'b1;
          end else begin
            a_q      <= a_q >> LIMB;
            b_q      <= b_q >> LIMB;
            chain_c  <= limb_sum[LIMB];
            result_q <= result_shift;
            idx      <= idx + 1'b1;
            if (last_limb) begin
              carry_q <= limb_sum[LIMB];
              state   <= S_DONE;
              o_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (flush || i_ready) begin
            state   <= S_IDLE;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_result = result_q;
  assign o_carry  = carry_q;
  assign o_float  = float_q;

endmodule

// File: tb/tb_ecc_seq_alu.sv
// Directed bench for ecc_seq_alu at WORD_SIZE=256, LIMB=32 with hand-computed expectations.
module tb_ecc_seq_alu;

  localparam int W = 256;

  localparam logic [4:0] OP_ADD  = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_TCS  = 5'b10100;
  localparam logic [4:0] OP_ADDC = 5'b10110;
  localparam logic [4:0] OP_GCAR = 5'b10111;
  localparam logic [4:0] OP_DECF = 5'b11000;
  localparam logic [4:0] OP_LDF  = 5'b11001;
  localparam logic [4:0] OP_BAD  = 5'b00000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [19:0]   i_insn = '0;
  logic [W-1:0]  i_r1data = '0;
  logic [W-1:0]  i_r2data = '0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [W-1:0]  o_result;
  logic          o_carry;
  logic [8:0]    o_float;
`ifdef SEQ_ALU_FLUSH_EN
  logic          i_flush = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int lat;

  ecc_seq_alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_insn   (i_insn),
    .i_r1data (i_r1data),
    .i_r2data (i_r2data),
`ifdef SEQ_ALU_FLUSH_EN
    .i_flush  (i_flush),
`endif
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_carry  (o_carry),
    .o_float  (o_float)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op and wait (bounded) for o_valid; lat counts edges after the accept edge.
  task automatic launch(input logic [4:0] op, input logic [W-1:0] r1, input logic [W-1:0] r2,
                        output int n);
    int w = 0;
    while (!o_ready && w < 100) begin @(posedge clk); #1; w++; end
    i_insn   = {op, 15'd0};
    i_r1data = r1;
    i_r2data = r2;
    i_valid  = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 100) begin @(posedge clk); #1; n++; end
  endtask

  task automatic retire();
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    check("idle_after_ready", {255'd0, o_ready}, 256'd1);
  endtask

  initial begin
    logic [W-1:0] ones;
    ones = '1;

    #12;
    check("rst_ready",  {255'd0, o_ready}, 256'd1);
    check("rst_valid",  {255'd0, o_valid}, 256'd0);
    check("rst_result", o_result, 256'd0);
    check("rst_carry",  {255'd0, o_carry}, 256'd0);
    check("rst_float",  W'(o_float), 256'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD wrap across all eight limbs
    launch(OP_ADD, ones, 256'd1, lat);
    check("add_latency", W'(lat), 256'd8);
    check("add_result",  o_result, 256'd0);
    check("add_carry",   {255'd0, o_carry}, 256'd1);
    retire();

    launch(OP_SUB, 256'd7, 256'd5, lat);
    check("sub_7_5_result", o_result, 256'd2);
    check("sub_7_5_carry",  {255'd0, o_carry}, 256'd1);
    retire();
    launch(OP_SUB, 256'd5, 256'd7, lat);
    check("sub_5_7_result", o_result, ones - 256'd1);
    check("sub_5_7_carry",  {255'd0, o_carry}, 256'd0);
    retire();

    // Set carry, then ADDC ripples across the limb boundary
    launch(OP_SUB, 256'd7, 256'd5, lat);
    retire();
    check("pre_addc_carry", {255'd0, o_carry}, 256'd1);
    launch(OP_ADDC, 256'hFFFF_FFFF, 256'd0, lat);
    check("addc_result", o_result, 256'h1_0000_0000);
    check("addc_carry",  {255'd0, o_carry}, 256'd0);
    retire();
    launch(OP_GCAR, 256'd0, 256'd0, lat);
    check("gcar0_latency", W'(lat), 256'd0);
    check("gcar0_result",  o_result, 256'd0);
    retire();

    launch(OP_TCS, 256'd0, 256'd0, lat);
    check("tcs0_result", o_result, 256'd0);
    check("tcs0_carry",  {255'd0, o_carry}, 256'd1);
    retire();
    launch(OP_GCAR, 256'd0, 256'd0, lat);
    check("gcar1_result", o_result, 256'd1);
    retire();
    launch(OP_TCS, 256'd1, 256'd0, lat);
    check("tcs1_result", o_result, ones);
    check("tcs1_carry",  {255'd0, o_carry}, 256'd0);
    retire();

    launch(OP_AND, 256'hF0F0, 256'hFF00, lat);
    check("and_result", o_result, 256'hF000);
    check("and_carry",  {255'd0, o_carry}, 256'd0);
    retire();
    launch(OP_BAD, 256'd9, 256'd9, lat);
    check("bad_op_result", o_result, 256'hDEED);
    check("bad_op_float",  W'(o_float), 256'd0);
    retire();

    // Back-pressure in DONE while i_valid toggles with an LDF that must not be taken
    launch(OP_ADD, 256'd3, 256'd4, lat);
    i_insn   = {OP_LDF, 15'd0};
    i_r1data = 256'd5;
    for (int i = 0; i < 10; i++) begin
      i_valid = ~i_valid;
      @(posedge clk); #1;
      check("hold_valid",  {255'd0, o_valid}, 256'd1);
      check("hold_result", o_result, 256'd7);
      check("hold_carry",  {255'd0, o_carry}, 256'd0);
      check("hold_ready",  {255'd0, o_ready}, 256'd0);
    end
    i_valid = 1'b0;
    retire();
    check("release_valid", {255'd0, o_valid}, 256'd0);
    check("no_accept_float", W'(o_float), 256'd0);

    launch(OP_LDF, 256'h200, 256'd0, lat);
    check("ldf_result", o_result, 256'd0);
    check("ldf_float",  W'(o_float), 256'd0);
    retire();
    launch(OP_DECF, 256'd0, 256'd0, lat);
    check("decf_result", o_result, 256'd511);
    check("decf_float",  W'(o_float), 256'd511);
    retire();
    launch(OP_TCS, 256'd0, 256'd0, lat);
    retire();
    check("pre_rst_carry", {255'd0, o_carry}, 256'd1);

    // Reset while limb 3 of an ADD is in flight
    i_insn   = {OP_ADD, 15'd0};
    i_r1data = ones;
    i_r2data = 256'd1;
    i_valid  = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {255'd0, o_valid}, 256'd0);
    check("midrst_carry", {255'd0, o_carry}, 256'd0);
    check("midrst_float", W'(o_float), 256'd0);
    check("midrst_ready", {255'd0, o_ready}, 256'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    launch(OP_ADD, 256'd1, 256'd1, lat);
    check("post_rst_latency", W'(lat), 256'd8);
    check("post_rst_result",  o_result, 256'd2);
    retire();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
